seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment driver for N common-anode or common-cathode digits. It takes a packed hex value, per-digit decimal points and enables, and scans the digits in time slots. Each slot has a programmable blanking dead time against ghosting and PWM brightness control. Optional leading-zero suppression is supported. It sits between the display-value logic and the board's segment/common pins, and replaces the fixed two-digit scan in the top level.

---
 rtl/seg_scan_driver_pkg.sv | 21 ++
 rtl/seg_hex_decode.sv | 14 +
 rtl/seg_scan_driver.sv | 206 ++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared seven-segment constants and pin-polarity helper for the display blocks.
// Patterns are active-high, bit 0 = segment a through bit 6 = segment g.
package seg_scan_driver_pkg;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Maps an active-high bundle onto the pin level of the board.
    function automatic logic [7:0] apply_polarity(input logic active_low, input logic [7:0] bits_in);
        logic [7:0] pins;
        if (active_low) begin
            pins = ~bits_in;
        end else begin
            pins = bits_in;
        end
        return pins;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg_hex_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Table lookup covers the full 0-F range, so no fallback is needed.
    always_comb begin
        pattern = SEG_HEX[nibble];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: shadow/frame buffering, per-slot dead time,
// PWM brightness and leading-zero blanking, with all pins driven from flops.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int CLK_HZ       = 12_000_000,
    parameter int DIGITS       = 4,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_W     = 4,
    parameter int COM_ANODE    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lz_suppress,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     com,
    output logic                  frame_done
);

    localparam int SLOT_LEN = CLK_HZ / (REFRESH_HZ * DIGITS);
    localparam int PH_W     = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int SL_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PH_W-1:0]   PH_LAST        = PH_W'(SLOT_LEN - 1);
    localparam logic [PH_W-1:0]   PH_BLANK       = PH_W'(BLANK_CYCLES);
    localparam logic [SL_W-1:0]   SL_LAST        = SL_W'(DIGITS - 1);
    localparam logic              SEG_ACTIVE_LOW = (COM_ANODE != 0) ? 1'b1 : 1'b0;
    localparam logic [7:0]        SEG_IDLE       = apply_polarity(SEG_ACTIVE_LOW, 8'h00);
    localparam logic [DIGITS-1:0] COM_IDLE       = SEG_ACTIVE_LOW ? {DIGITS{1'b0}} : {DIGITS{1'b1}};

    if (SLOT_LEN < BLANK_CYCLES + 1) begin : g_slot_too_short
        $error("seg_scan_driver: slot of %0d cycles cannot hold %0d dead cycles plus an on-cycle",
               SLOT_LEN, BLANK_CYCLES);
    end
    if ((DIGITS < 1) || (DIGITS > 8)) begin : g_digits_range
        $error("seg_scan_driver: DIGITS=%0d outside 1..8", DIGITS);
    end

    logic [PH_W-1:0]     phase_q, phase_d;
    logic [SL_W-1:0]     slot_q, slot_d;
    logic [BRIGHT_W-1:0] pwm_q, pwm_d;
    logic [4*DIGITS-1:0] shadow_value_q, shadow_value_d, frame_value_q, frame_value_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d, frame_dp_q, frame_dp_d;
    logic [DIGITS-1:0]   shadow_en_q, shadow_en_d, frame_en_q, frame_en_d;
    logic [6:0]          seg_q, seg_d;
    logic                seg_dp_q, seg_dp_d;
    logic [DIGITS-1:0]   com_q, com_d;
    logic                frame_done_q, frame_done_d;

    logic                boundary_s;
    logic [3:0]          nibble_s;
    logic [6:0]          pattern_s;
    logic [DIGITS-1:0]   lz_mask_s;
    logic                lit_s;
    logic                digit_dp_s;
    logic                digit_lz_s;
    logic [6:0]          seg_act_s;
    logic                dp_act_s;
    logic [DIGITS-1:0]   com_act_s;
    logic [7:0]          seg_pins_s;

    seg_hex_decode u_hex_decode (
        .nibble  (nibble_s),
        .pattern (pattern_s)
    );

    // Scan counters; the PWM count restarts so it reads 0 on the first on-cycle of each slot.
    always_comb begin
        boundary_s = (slot_q == {SL_W{1'b0}}) && (phase_q == {PH_W{1'b0}});
        if (phase_q == PH_LAST) begin
            phase_d = {PH_W{1'b0}};
            if (slot_q == SL_LAST) begin
                slot_d = {SL_W{1'b0}};
            end else begin
                slot_d = slot_q + SL_W'(1);
            end
        end else begin
            phase_d = phase_q + PH_W'(1);
            slot_d  = slot_q;
        end
        if (phase_d <= PH_BLANK) begin
            pwm_d = {BRIGHT_W{1'b0}};
        end else begin
            pwm_d = pwm_q + BRIGHT_W'(1);
        end
    end

    // Shadow capture and frame-boundary transfer; a load on the boundary bypasses the shadow.
    always_comb begin
        if (load) begin
            shadow_value_d = value;
            shadow_dp_d    = dp;
            shadow_en_d    = digit_en;
        end else begin
            shadow_value_d = shadow_value_q;
            shadow_dp_d    = shadow_dp_q;
            shadow_en_d    = shadow_en_q;
        end
        if (boundary_s && load) begin
            frame_value_d = value;
            frame_dp_d    = dp;
            frame_en_d    = digit_en;
        end else if (boundary_s) begin
            frame_value_d = shadow_value_q;
            frame_dp_d    = shadow_dp_q;
            frame_en_d    = shadow_en_q;
        end else begin
            frame_value_d = frame_value_q;
            frame_dp_d    = frame_dp_q;
            frame_en_d    = frame_en_q;
        end
    end

    // Leading-zero mask scanned from the top digit down; digit 0 always stays visible.
    always_comb begin : lz_mask_proc
        logic higher_zero;
        higher_zero = 1'b1;
        lz_mask_s   = {DIGITS{1'b0}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero && (frame_value_d[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lz_mask_s[i] = lz_suppress && higher_zero;
            end else begin
                lz_mask_s[i] = 1'b0;
            end
        end
        nibble_s = frame_value_d[{slot_q, 2'b00} +: 4];
    end

    // Next pin values: dark during dead time, PWM-off cycles, disabled or suppressed digits.
    always_comb begin
        digit_dp_s = frame_dp_d[slot_q];
        digit_lz_s = lz_mask_s[slot_q];
        lit_s      = (phase_q >= PH_BLANK) && (pwm_q <= brightness) && frame_en_d[slot_q]
                     && (!digit_lz_s || digit_dp_s);
        com_act_s  = {DIGITS{1'b0}};
        seg_act_s  = 7'h00;
        dp_act_s   = 1'b0;
        if (lit_s) begin
            com_act_s[slot_q] = 1'b1;
            dp_act_s          = digit_dp_s;
            if (digit_lz_s) begin
                seg_act_s = 7'h00;
            end else begin
                seg_act_s = pattern_s;
            end
        end else begin
            com_act_s = {DIGITS{1'b0}};
        end
        seg_pins_s = apply_polarity(SEG_ACTIVE_LOW, {dp_act_s, seg_act_s});
        seg_d      = seg_pins_s[6:0];
        seg_dp_d   = seg_pins_s[7];
        if (SEG_ACTIVE_LOW) begin
            com_d = com_act_s;
        end else begin
            com_d = ~com_act_s;
        end
        frame_done_d = (slot_q == SL_LAST) && (phase_q == PH_LAST);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q        <= {PH_W{1'b0}};
            slot_q         <= {SL_W{1'b0}};
            pwm_q          <= {BRIGHT_W{1'b0}};
            shadow_value_q <= {(4*DIGITS){1'b0}};
            shadow_dp_q    <= {DIGITS{1'b0}};
            shadow_en_q    <= {DIGITS{1'b0}};
            frame_value_q  <= {(4*DIGITS){1'b0}};
            frame_dp_q     <= {DIGITS{1'b0}};
            frame_en_q     <= {DIGITS{1'b0}};
            seg_q          <= SEG_IDLE[6:0];
            seg_dp_q       <= SEG_IDLE[7];
            com_q          <= COM_IDLE;
            frame_done_q   <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            slot_q         <= slot_d;
            pwm_q          <= pwm_d;
            shadow_value_q <= shadow_value_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_en_q    <= shadow_en_d;
            frame_value_q  <= frame_value_d;
            frame_dp_q     <= frame_dp_d;
            frame_en_q     <= frame_en_d;
            seg_q          <= seg_d;
            seg_dp_q       <= seg_dp_d;
            com_q          <= com_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign seg_dp     = seg_dp_q;
    assign com        = com_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a cycle model predicts the pins after every edge.
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int BW     = 2;
    localparam int BLANK  = 4;
    localparam int S      = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [15:0]   value = 16'h0000;
    logic [3:0]    dp = 4'h0;
    logic [3:0]    digit_en = 4'h0;
    logic          lz_suppress = 1'b0;
    logic [BW-1:0] brightness = 2'd3;
    logic          load = 1'b0;
    logic [6:0]    seg;
    logic          seg_dp;
    logic [3:0]    com;
    logic          frame_done;

    seg_scan_driver #(
        .CLK_HZ(64000), .DIGITS(DIGITS), .REFRESH_HZ(1000),
        .BLANK_CYCLES(BLANK), .BRIGHT_W(BW), .COM_ANODE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .digit_en(digit_en),
        .lz_suppress(lz_suppress), .brightness(brightness), .load(load),
        .seg(seg), .seg_dp(seg_dp), .com(com), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] com;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_slot = 0;
    int          m_phase = 0;
    logic [15:0] m_sh_val = 16'h0, m_fr_val = 16'h0;
    logic [3:0]  m_sh_dp = 4'h0, m_fr_dp = 4'h0, m_sh_en = 4'h0, m_fr_en = 4'h0;
    int          fd_pulses = 0;
    int          lit_total = 0;
    int          blank_run = 0;
    logic [3:0]  prev_com = 4'h0;
    int          lit_cnt [4];
    logic [6:0]  obs_seg [4];
    logic        obs_dp [4];

    function automatic logic [6:0] hex_shape(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  4'hF: return 7'b1110001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic clear_stats();
        fd_pulses = 0;
        lit_total = 0;
        for (int d = 0; d < DIGITS; d++) begin
            lit_cnt[d] = 0;
            obs_seg[d] = 7'h55;
            obs_dp[d]  = 1'b1;
        end
    endtask

    // One clock: predict, push, advance the model, then pop and compare after the edge.
    task automatic step();
        exp_t       e;
        exp_t       p;
        logic [3:0] nib;
        int         pwm;
        bit         supp;
        bit         lit;
        if (m_slot == 0 && m_phase == 0) begin
            if (load) begin
                m_fr_val = value; m_fr_dp = dp; m_fr_en = digit_en;
            end else begin
                m_fr_val = m_sh_val; m_fr_dp = m_sh_dp; m_fr_en = m_sh_en;
            end
        end
        if (load) begin
            m_sh_val = value; m_sh_dp = dp; m_sh_en = digit_en;
        end
        e = '0;
        e.fd = (m_slot == DIGITS - 1) && (m_phase == S - 1);
        if (m_phase >= BLANK) begin
            pwm  = (m_phase - BLANK) % 4;
            nib  = 4'(m_fr_val >> (4 * m_slot));
            supp = lz_suppress && (m_slot != 0) && ((m_fr_val >> (4 * m_slot)) == 16'h0);
            lit  = (pwm <= int'(brightness)) && m_fr_en[m_slot] && (!supp || m_fr_dp[m_slot]);
            if (lit) begin
                e.com = 4'(1 << m_slot);
                e.dp  = m_fr_dp[m_slot];
                e.seg = supp ? 7'h00 : hex_shape(nib);
            end
        end
        e.seg = ~e.seg;
        e.dp  = ~e.dp;
        exp_q.push_back(e);
        m_phase++;
        if (m_phase == S) begin
            m_phase = 0;
            m_slot  = (m_slot + 1) % DIGITS;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        p = exp_q.pop_front();
        check_eq("com", 32'(com), 32'(p.com));
        check_eq("seg", 32'(seg), 32'(p.seg));
        check_eq("seg_dp", 32'(seg_dp), 32'(p.dp));
        check_eq("frame_done", 32'(frame_done), 32'(p.fd));
        check_eq("com_onehot", 32'($countones(com) <= 1), 32'd1);
        if (frame_done) fd_pulses++;
        if (com == 4'b0000) begin
            blank_run++;
        end else begin
            if (com != prev_com) check_eq("dead_time", 32'(blank_run >= BLANK), 32'd1);
            prev_com  = com;
            blank_run = 0;
            lit_total++;
        end
        for (int d = 0; d < DIGITS; d++) begin
            if (com == 4'(1 << d)) begin
                lit_cnt[d]++;
                obs_seg[d] = seg;
                obs_dp[d]  = seg_dp;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to_boundary();
        int k;
        k = 0;
        while (!(m_slot == 0 && m_phase == 0) && k < S * DIGITS) begin
            step();
            k++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_com", 32'(com), 32'h0);
        check_eq("rst_seg", 32'(seg), 32'h7F);
        check_eq("rst_seg_dp", 32'(seg_dp), 32'h1);
        check_eq("rst_frame_done", 32'(frame_done), 32'h0);
        m_slot = 0; m_phase = 0;
        m_sh_val = 16'h0; m_sh_dp = 4'h0; m_sh_en = 4'h0;
        m_fr_val = 16'h0; m_fr_dp = 4'h0; m_fr_en = 4'h0;
        exp_q.delete();
        prev_com = 4'h0;
        blank_run = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_com", 32'(com), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        apply_reset();
        step();
        value = 16'h1234; dp = 4'h0; digit_en = 4'hF; brightness = 2'd3; load = 1'b1;
        step();
        run_to_boundary();
        clear_stats();
        run(S * DIGITS);
        check_eq("t1_frame_done", 32'(fd_pulses), 32'd1);
        check_eq("t1_lit_cycles", 32'(lit_total), 32'd48);
        check_eq("t1_digit0_4", 32'(obs_seg[0]), 32'(7'b0011001));
        check_eq("t1_digit1_3", 32'(obs_seg[1]), 32'(7'b0110000));
        check_eq("t1_digit2_2", 32'(obs_seg[2]), 32'(7'b0100100));
        check_eq("t1_digit3_1", 32'(obs_seg[3]), 32'(7'b1111001));

        brightness = 2'd1;
        clear_stats();
        run(S * DIGITS);
        check_eq("t3_frame_done", 32'(fd_pulses), 32'd1);
        check_eq("t3_lit_cycles", 32'(lit_total), 32'd24);
        brightness = 2'd3;

        value = 16'h0050; lz_suppress = 1'b1; load = 1'b1;
        step();
        run_to_boundary();
        clear_stats();
        run(S * DIGITS);
        check_eq("t4_d3_dark", 32'(lit_cnt[3]), 32'd0);
        check_eq("t4_d2_dark", 32'(lit_cnt[2]), 32'd0);
        check_eq("t4_d1_lit", 32'(lit_cnt[1]), 32'd12);
        check_eq("t4_d1_5", 32'(obs_seg[1]), 32'(7'b0010010));
        check_eq("t4_d0_0", 32'(obs_seg[0]), 32'(7'b1000000));

        value = 16'h0000; dp = 4'b0100; load = 1'b1;
        step();
        run_to_boundary();
        clear_stats();
        run(S * DIGITS);
        check_eq("t4_d2_dp_lit", 32'(lit_cnt[2]), 32'd12);
        check_eq("t4_d2_seg_off", 32'(obs_seg[2]), 32'(7'b1111111));
        check_eq("t4_d2_dp_on", 32'(obs_dp[2]), 32'd0);
        check_eq("t4_d1_dark", 32'(lit_cnt[1]), 32'd0);
        check_eq("t4_d0_0b", 32'(obs_seg[0]), 32'(7'b1000000));

        lz_suppress = 1'b0; dp = 4'h0; value = 16'h1234; load = 1'b1;
        step();
        run_to_boundary();
        run(S + 5);
        value = 16'hABCD; load = 1'b1;
        clear_stats();
        run_to_boundary();
        check_eq("t5_keep_old_d3", 32'(obs_seg[3]), 32'(7'b1111001));
        clear_stats();
        run(S * DIGITS);
        check_eq("t5_new_d0_d", 32'(obs_seg[0]), 32'(7'b0100001));
        check_eq("t5_new_d1_c", 32'(obs_seg[1]), 32'(7'b1000110));
        check_eq("t5_new_d2_b", 32'(obs_seg[2]), 32'(7'b0000011));
        check_eq("t5_new_d3_a", 32'(obs_seg[3]), 32'(7'b0001000));
        value = 16'h8888; load = 1'b1;
        clear_stats();
        run(S * DIGITS);
        check_eq("t5_bypass_d0_8", 32'(obs_seg[0]), 32'(7'b0000000));

        run(2 * S + 8);
        apply_reset();
        clear_stats();
        run(S * DIGITS);
        check_eq("t6_dark_after_rst", 32'(lit_total), 32'd0);
        check_eq("t6_frame_done", 32'(fd_pulses), 32'd1);
        value = 16'h0000; dp = 4'h0; digit_en = 4'hF; lz_suppress = 1'b1; load = 1'b1;
        step();
        run_to_boundary();
        clear_stats();
        run(S * DIGITS);
        check_eq("t6_d0_0", 32'(obs_seg[0]), 32'(7'b1000000));
        check_eq("t6_d0_lit", 32'(lit_cnt[0]), 32'd12);
        check_eq("t6_d3_dark", 32'(lit_cnt[3]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
